// File: rtl/lsu.sv
// Load/store unit: one valid/ready bus transaction per start pulse, with
// byte-lane steering, load extension and misaligned/illegal/timeout reporting.
module lsu #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] rs2_val,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault,
    output logic [31:0] load_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        fault_q, fault_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic illegal_c;
    logic misaligned_c;

    // Select the addressed lane and extend it according to the load width.
    function automatic logic [31:0] extract(input logic [31:0] rdata,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{24{lane[7]}}, lane[7:0]};
            3'b001:  extract = {{16{lane[15]}}, lane[15:0]};
            3'b100:  extract = {24'h0, lane[7:0]};
            3'b101:  extract = {16'h0, lane[15:0]};
            default: extract = lane;
        endcase
    endfunction

    always_comb begin
        illegal_c = 1'b0;
        if (is_load && is_store) begin
            illegal_c = 1'b1;
        end else if (is_load) begin
            illegal_c = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (is_store) begin
            illegal_c = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end
        misaligned_c = ((funct3[1:0] == 2'b01) && address[0]) ||
                       ((funct3 == 3'b010) && (address[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d = is_load;
                    funct3_d  = funct3;
                    off_d     = address[1:0];
                    if (illegal_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = F_ILLEGAL;
                    end else if ((is_load || is_store) && misaligned_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = F_MISALIGN;
                    end else if (!is_load && !is_store) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = F_OK;
                    end else begin
                        state_d     = REQ;
                        busy_d      = 1'b1;
                        cnt_d       = '0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {address[31:2], 2'b00};
                        mem_we_d    = is_store;
                        mem_wstrb_d = 4'b0000;
                        mem_wdata_d = 32'h0;
                        // Store lanes: replicate data, strobe the addressed bytes.
                        if (is_store) begin
                            case (funct3[1:0])
                                2'b00: begin
                                    mem_wdata_d = {4{rs2_val[7:0]}};
                                    mem_wstrb_d = 4'b0001 << address[1:0];
                                end
                                2'b01: begin
                                    mem_wdata_d = {2{rs2_val[15:0]}};
                                    mem_wstrb_d = 4'b0011 << {address[1], 1'b0};
                                end
                                default: begin
                                    mem_wdata_d = rs2_val;
                                    mem_wstrb_d = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (is_load_q) begin
                        load_data_d = extract(mem_rdata, off_q, funct3_q);
                    end
                    state_d = DONE;
                    fault_d = F_OK;
                end else if ((TIMEOUT != 0) &&
                             (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT))) begin
                    state_d = DONE;
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
                if (state_d == DONE) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= F_OK;
            load_data_q <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, fault paths, timeout and async reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = 32'h0;
    logic [31:0] rs2_val = 32'h0;
    logic        busy;
    logic        done;
    logic [1:0]  fault;
    logic [31:0] load_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .address   (address),
        .rs2_val   (rs2_val),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .load_data (load_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns in the cycle right after that edge.
    task automatic do_start(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; address = a; rs2_val = d;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic bus_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [31:0] exp);
        do_start(1'b1, 1'b0, f3, a, 32'h0);
        chk({tag, " valid"}, 32'(mem_valid), 32'd1);
        chk({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " wstrb"}, 32'(mem_wstrb), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        mem_ready = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd0);
        chk({tag, " data"}, load_data, exp);
        chk({tag, " valid_off"}, 32'(mem_valid), 32'd0);
        @(negedge clk);
        chk({tag, " done_off"}, 32'(done), 32'd0);
    endtask

    task automatic bus_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] ld_hold);
        do_start(1'b0, 1'b1, f3, a, d);
        chk({tag, " valid"}, 32'(mem_valid), 32'd1);
        chk({tag, " we"}, 32'(mem_we), 32'd1);
        chk({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " wstrb"}, 32'(mem_wstrb), 32'(strb));
        chk({tag, " wdata"}, mem_wdata, wdata);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd0);
        chk({tag, " ld_hold"}, load_data, ld_hold);
        @(negedge clk);
    endtask

    task automatic quick(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a, input logic [1:0] exp_f);
        do_start(ld, st, f3, a, 32'h0);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'(exp_f));
        chk({tag, " no_bus"}, 32'(mem_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_off"}, 32'(done), 32'd0);
        chk({tag, " no_bus2"}, 32'(mem_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst valid", 32'(mem_valid), 32'd0);

        bus_load("LB", 3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        bus_load("LHU", 3'b101, 32'h202, 32'hBEEF_1234, 32'h0000_BEEF);
        bus_load("LH", 3'b001, 32'h202, 32'hBEEF_1234, 32'hFFFF_BEEF);
        bus_load("LBU", 3'b100, 32'h101, 32'h0000_9A00, 32'h0000_009A);

        bus_store("SB", 3'b000, 32'h301, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, 32'h0000_009A);
        bus_store("SH", 3'b001, 32'h302, 32'h1234_56AB, 4'b1100, 32'h56AB_56AB, 32'h0000_009A);
        bus_store("SW", 3'b010, 32'h304, 32'h1234_56AB, 4'b1111, 32'h1234_56AB, 32'h0000_009A);

        quick("LW mis", 1'b1, 1'b0, 3'b010, 32'h402, 2'b01);
        quick("LH mis", 1'b1, 1'b0, 3'b001, 32'h401, 2'b01);
        quick("SB f100", 1'b0, 1'b1, 3'b100, 32'h400, 2'b11);
        quick("LD+ST", 1'b1, 1'b1, 3'b000, 32'h400, 2'b11);
        quick("noop", 1'b0, 1'b0, 3'b010, 32'h400, 2'b00);
        chk("noop ld_hold", load_data, 32'h0000_009A);

        // Timeout with a second start issued mid-wait.
        do_start(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("TO valid1", 32'(mem_valid), 32'd1);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; address = 32'h20;
        @(negedge clk);
        start = 1'b0; is_store = 1'b0;
        chk("TO valid2", 32'(mem_valid), 32'd1);
        @(negedge clk);
        chk("TO valid3", 32'(mem_valid), 32'd1);
        @(negedge clk);
        chk("TO valid4", 32'(mem_valid), 32'd1);
        chk("TO addr", mem_addr, 32'h10);
        chk("TO we", 32'(mem_we), 32'd0);
        chk("TO no_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("TO done", 32'(done), 32'd1);
        chk("TO fault", 32'(fault), 32'd2);
        chk("TO valid_off", 32'(mem_valid), 32'd0);
        chk("TO ld_hold", load_data, 32'h0000_009A);
        @(negedge clk);
        chk("TO done_off", 32'(done), 32'd0);
        chk("TO fault_hold", 32'(fault), 32'd2);
        chk("TO no_restart", 32'(mem_valid), 32'd0);

        // Asynchronous reset in the middle of a request.
        do_start(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        chk("RST pre valid", 32'(mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("RST async valid", 32'(mem_valid), 32'd0);
        chk("RST async busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("RST post done", 32'(done), 32'd0);
        chk("RST post valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        chk("RST post done2", 32'(done), 32'd0);
        bus_load("LW0", 3'b010, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
